// File: rtl/systolic_feed_skew.sv
// Systolic n-body feeder: buffers a batch of N bodies, then streams them onto the
// array's west (row) and north (column) edges with a one-step-per-lane diagonal skew.
module systolic_feed_skew #(
  parameter int N = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  real          in_q [3],
  input  real          in_m,
  output real          row_q [N][3],
  output real          row_m [N],
  output logic [N-1:0] row_v,
  output real          col_q [N][3],
  output real          col_m [N],
  output logic [N-1:0] col_v,
  output logic         busy,
  output logic         done
);

  localparam int WW = (N > 1) ? $clog2(N) : 1;
  localparam int TW = (N > 1) ? $clog2(2 * N - 1) : 1;
  localparam logic [WW-1:0] WR_LAST = WW'(N - 1);
  localparam logic [TW-1:0] T_LAST  = TW'(2 * N - 2);

  typedef enum logic [1:0] {LOAD = 2'd0, DRIVE = 2'd1, DONE = 2'd2} state_t;

  state_t        state_r, state_s;
  logic [WW-1:0] wr_r, wr_s;
  logic [TW-1:0] t_r, t_s;
  logic [TW-1:0] step_s;
  logic          emit_s;
  logic          load_s;

  real buf_q_r [N][3];
  real buf_m_r [N];

  real          row_q_r [N][3];
  real          row_m_r [N];
  logic [N-1:0] row_v_r;
  real          col_q_r [N][3];
  real          col_m_r [N];
  logic [N-1:0] col_v_r;

  real          slot_q_s [N][3];
  real          slot_m_s [N];
  logic [N-1:0] slot_v_s;

  // Next-state, write enable and the drive step to be registered on this edge.
  always_comb begin
    state_s = state_r;
    wr_s    = wr_r;
    t_s     = t_r;
    step_s  = '0;
    emit_s  = 1'b0;
    load_s  = 1'b0;
    case (state_r)
      LOAD: begin
        if (in_valid) begin
          load_s = 1'b1;
          if (wr_r == WR_LAST) begin
            state_s = DRIVE;
            wr_s    = '0;
            t_s     = '0;
            emit_s  = 1'b1;
          end else begin
            wr_s = wr_r + {{(WW-1){1'b0}}, 1'b1};
          end
        end else begin
          wr_s = wr_r;
        end
      end
      DRIVE: begin
        if (t_r == T_LAST) begin
          state_s = DONE;
          t_s     = '0;
        end else begin
          t_s    = t_r + {{(TW-1){1'b0}}, 1'b1};
          step_s = t_s;
          emit_s = 1'b1;
        end
      end
      DONE: begin
        state_s = LOAD;
      end
      default: begin
        state_s = LOAD;
        wr_s    = '0;
        t_s     = '0;
      end
    endcase
  end

  // Skewed slot contents; the body being written this edge is forwarded (needed for N=1).
  always_comb begin
    slot_v_s = '0;
    for (int r = 0; r < N; r++) begin
      slot_m_s[r] = 0.0;
      for (int j = 0; j < 3; j++) begin
        slot_q_s[r][j] = 0.0;
      end
      for (int k = 0; k < N; k++) begin
        if (emit_s && (int'(step_s) == r + k)) begin
          slot_v_s[r] = 1'b1;
          if (load_s && (wr_r == WW'(k))) begin
            slot_m_s[r] = in_m;
            for (int j = 0; j < 3; j++) begin
              slot_q_s[r][j] = in_q[j];
            end
          end else begin
            slot_m_s[r] = buf_m_r[k];
            for (int j = 0; j < 3; j++) begin
              slot_q_s[r][j] = buf_q_r[k][j];
            end
          end
        end else begin
          slot_v_s[r] = slot_v_s[r];
        end
      end
    end
  end

  // State, counters, body buffer and registered edge outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= LOAD;
      wr_r    <= '0;
      t_r     <= '0;
      row_v_r <= '0;
      col_v_r <= '0;
      for (int r = 0; r < N; r++) begin
        row_m_r[r] <= 0.0;
        col_m_r[r] <= 0.0;
        buf_m_r[r] <= 0.0;
        for (int j = 0; j < 3; j++) begin
          row_q_r[r][j] <= 0.0;
          col_q_r[r][j] <= 0.0;
          buf_q_r[r][j] <= 0.0;
        end
      end
    end else begin
      state_r <= state_s;
      wr_r    <= wr_s;
      t_r     <= t_s;
      row_v_r <= slot_v_s;
      col_v_r <= slot_v_s;
      for (int r = 0; r < N; r++) begin
        row_m_r[r] <= slot_m_s[r];
        col_m_r[r] <= slot_m_s[r];
        for (int j = 0; j < 3; j++) begin
          row_q_r[r][j] <= slot_q_s[r][j];
          col_q_r[r][j] <= slot_q_s[r][j];
        end
      end
      if (load_s) begin
        buf_m_r[wr_r] <= in_m;
        for (int j = 0; j < 3; j++) begin
          buf_q_r[wr_r][j] <= in_q[j];
        end
      end
    end
  end

  assign in_ready = (state_r == LOAD);
  assign busy     = (state_r != LOAD);
  assign done     = (state_r == DONE);
  assign row_v    = row_v_r;
  assign col_v    = col_v_r;
  assign row_q    = row_q_r;
  assign row_m    = row_m_r;
  assign col_q    = col_q_r;
  assign col_m    = col_m_r;

endmodule

// File: tb/tb_systolic_feed_skew.sv
// Randomized scoreboard bench for systolic_feed_skew (N=2 main instance, N=3 gapped-input instance).
module tb_systolic_feed_skew;
  localparam int N = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset;
  logic         in_valid;
  logic         in_ready;
  real          in_q [3];
  real          in_m;
  real          row_q [N][3];
  real          row_m [N];
  logic [N-1:0] row_v;
  real          col_q [N][3];
  real          col_m [N];
  logic [N-1:0] col_v;
  logic         busy;
  logic         done;

  logic       in_valid3;
  logic       in_ready3;
  real        in_q3 [3];
  real        in_m3;
  real        row_q3 [3][3];
  real        row_m3 [3];
  logic [2:0] row_v3;
  real        col_q3 [3][3];
  real        col_m3 [3];
  logic [2:0] col_v3;
  logic       busy3;
  logic       done3;

  systolic_feed_skew #(.N(N)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_q(in_q), .in_m(in_m), .row_q(row_q), .row_m(row_m), .row_v(row_v),
    .col_q(col_q), .col_m(col_m), .col_v(col_v), .busy(busy), .done(done)
  );

  systolic_feed_skew #(.N(3)) dut3 (
    .clk(clk), .reset(reset), .in_valid(in_valid3), .in_ready(in_ready3),
    .in_q(in_q3), .in_m(in_m3), .row_q(row_q3), .row_m(row_m3), .row_v(row_v3),
    .col_q(col_q3), .col_m(col_m3), .col_v(col_v3), .busy(busy3), .done(done3)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cycle    = 0;
  always @(posedge clk) cycle++;

  real          bq [N][3];
  real          bm [N];
  real          exp_q [$];
  real          exp_m [$];
  logic [N-1:0] exp_v [$];

  task automatic chk_r(input string name, input real act, input real exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %f, expected %f (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_b(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic real rnd();
    return (real'($urandom_range(0, 400)) - 200.0) / 4.0;
  endfunction

  // Reference: at step t, lane r carries body t-r if that index exists, else a zero bubble.
  task automatic push_batch();
    for (int t = 0; t < 2 * N - 1; t++) begin
      logic [N-1:0] v;
      v = '0;
      for (int r = 0; r < N; r++) begin
        int k;
        k = t - r;
        if (k >= 0 && k < N) begin
          v[r] = 1'b1;
          exp_m.push_back(bm[k]);
          for (int j = 0; j < 3; j++) exp_q.push_back(bq[k][j]);
        end else begin
          exp_m.push_back(0.0);
          for (int j = 0; j < 3; j++) exp_q.push_back(0.0);
        end
      end
      exp_v.push_back(v);
    end
  endtask

  task automatic send(input real x, input real y, input real z, input real m, input int k);
    int w;
    in_q[0] = x; in_q[1] = y; in_q[2] = z; in_m = m;
    in_valid = 1'b1;
    w = 0;
    while (!in_ready && w < 40) begin
      @(posedge clk); #1;
      w++;
    end
    if (!in_ready) begin
      n_checks++; n_fail++;
      $display("FAIL send_timeout: in_ready stayed 0 for %0d cycles", w);
      in_valid = 1'b0;
    end else begin
      @(posedge clk); #1;
      bq[k][0] = x; bq[k][1] = y; bq[k][2] = z; bm[k] = m;
      if (k == N - 1) push_batch();
    end
  endtask

  task automatic wait_done();
    int w;
    w = 0;
    while (!done && w < 50) begin
      @(posedge clk); #1;
      w++;
    end
    chk_b("done_seen", done, 1);
  endtask

  // Monitor: drive cycles are popped from the scoreboard; all other cycles must be all-zero.
  logic [N-1:0] mon_v;
  real          mon_m;
  real          mon_q;
  always @(negedge clk) begin
    if (!reset) begin
      chk_b("in_ready_vs_busy", in_ready, !busy);
      if (busy && !done) begin
        if (exp_v.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL drive_unexpected: row_v=%b with empty scoreboard", row_v);
        end else begin
          mon_v = exp_v.pop_front();
          chk_b("row_v", row_v, mon_v);
          chk_b("col_v", col_v, mon_v);
          for (int r = 0; r < N; r++) begin
            mon_m = exp_m.pop_front();
            chk_r("row_m", row_m[r], mon_m);
            chk_r("col_m", col_m[r], mon_m);
            for (int j = 0; j < 3; j++) begin
              mon_q = exp_q.pop_front();
              chk_r("row_q", row_q[r][j], mon_q);
              chk_r("col_q", col_q[r][j], mon_q);
            end
          end
        end
      end else begin
        chk_b("idle_row_v", row_v, 0);
        chk_b("idle_col_v", col_v, 0);
        for (int r = 0; r < N; r++) begin
          chk_r("idle_row_m", row_m[r], 0.0);
          chk_r("idle_col_q", col_q[r][0], 0.0);
        end
      end
    end
  end

  initial begin
    int c0;
    int c1;
    int idx;
    int drive_cycles;
    logic [5:0] pat;
    real b3q [3][3];
    real b3m [3];

    reset = 1'b1;
    in_valid = 1'b0; in_m = 0.0;
    in_valid3 = 1'b0; in_m3 = 0.0;
    for (int j = 0; j < 3; j++) begin in_q[j] = 0.0; in_q3[j] = 0.0; end
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    chk_b("rst_busy", busy, 0);
    chk_b("rst_in_ready", in_ready, 1);
    chk_b("rst_done", done, 0);
    chk_b("rst_row_v", row_v, 0);

    // Directed batch.
    send(-3.0, -2.0, -2.0, 1.0, 0);
    send(-1.0, -1.0, 0.0, 1.0, 1);
    in_valid = 1'b0;
    chk_b("step0_row_v", row_v, 1);
    chk_r("step0_row_q0x", row_q[0][0], -3.0);
    chk_r("step0_col_q0z", col_q[0][2], -2.0);
    wait_done();
    @(posedge clk); #1;

    // Backpressure: in_valid held with junk through DRIVE.
    send(rnd(), rnd(), rnd(), rnd(), 0);
    send(rnd(), rnd(), rnd(), rnd(), 1);
    in_q[0] = 9.0; in_q[1] = 9.0; in_q[2] = 9.0; in_m = 9.0;
    in_valid = 1'b1;
    wait_done();
    in_valid = 1'b0;
    @(posedge clk); #1;

    // Reset in the middle of DRIVE, then reload.
    send(rnd(), rnd(), rnd(), rnd(), 0);
    send(rnd(), rnd(), rnd(), rnd(), 1);
    in_valid = 1'b0;
    @(posedge clk); #1;
    #2 reset = 1'b1;
    #1;
    chk_b("midrst_row_v", row_v, 0);
    chk_b("midrst_busy", busy, 0);
    chk_b("midrst_in_ready", in_ready, 1);
    chk_r("midrst_row_q", row_q[0][0], 0.0);
    chk_r("midrst_col_m", col_m[1], 0.0);
    exp_q.delete(); exp_m.delete(); exp_v.delete();
    @(posedge clk); #1 reset = 1'b0;
    send(2.0, 2.0, 2.0, 1.0, 0);
    send(-2.0, -2.0, 0.0, 1.0, 1);
    in_valid = 1'b0;
    chk_r("reload_row_q0", row_q[0][0], 2.0);
    chk_b("reload_row_v", row_v, 1);
    wait_done();
    @(posedge clk); #1;

    // Back-to-back batches at full input rate.
    send(rnd(), rnd(), rnd(), rnd(), 0);
    send(rnd(), rnd(), rnd(), rnd(), 1);
    c0 = cycle;
    send(rnd(), rnd(), rnd(), rnd(), 0);
    send(rnd(), rnd(), rnd(), rnd(), 1);
    c1 = cycle;
    in_valid = 1'b0;
    chk_b("b2b_gap", c1 - c0, 6);
    wait_done();
    @(posedge clk); #1;

    // Random batches with random input gaps.
    for (int b = 0; b < 6; b++) begin
      for (int k = 0; k < N; k++) begin
        in_valid = 1'b0;
        repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        send(rnd(), rnd(), rnd(), rnd(), k);
      end
      in_valid = 1'b0;
      wait_done();
      @(posedge clk); #1;
    end

    // N=3 gapped input: valid pattern 1,0,0,1,0,1 (bit 0 first).
    pat = 6'b101001;
    idx = 0;
    for (int k = 0; k < 3; k++) begin
      b3m[k] = rnd();
      for (int j = 0; j < 3; j++) b3q[k][j] = rnd();
    end
    for (int i = 0; i < 6; i++) begin
      in_valid3 = pat[i];
      in_m3 = b3m[idx];
      for (int j = 0; j < 3; j++) in_q3[j] = b3q[idx][j];
      if (i == 5) chk_b("gap_busy_before_last", busy3, 0);
      @(posedge clk); #1;
      if (pat[i]) idx++;
    end
    in_valid3 = 1'b0;
    chk_b("gap_step0_row_v", row_v3, 1);
    chk_b("gap_step0_col_v", col_v3, 1);
    chk_r("gap_step0_row_q0x", row_q3[0][0], b3q[0][0]);
    chk_r("gap_step0_row_q0z", row_q3[0][2], b3q[0][2]);
    chk_r("gap_step0_row_m0", row_m3[0], b3m[0]);
    chk_r("gap_step0_row_q1", row_q3[1][0], 0.0);
    drive_cycles = 0;
    while (busy3 && !done3 && drive_cycles < 20) begin
      if (drive_cycles == 4) begin
        chk_b("gap_step4_row_v", row_v3, 4);
        chk_r("gap_step4_row_m2", row_m3[2], b3m[2]);
      end
      @(posedge clk); #1;
      drive_cycles++;
    end
    chk_b("gap_drive_len", drive_cycles, 5);
    chk_b("gap_done", done3, 1);
    @(posedge clk); #1;
    chk_b("gap_back_to_load", in_ready3, 1);

    chk_b("scoreboard_drained", exp_v.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
